// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per cycle, LSB first,
// carrying between digits in a single register; reports cout and signed overflow on completion.
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH % DIGIT) != 0 || STEPS < 2) begin : g_bad_params
    $error("serial_digit_adder: WIDTH must be a multiple of DIGIT with at least two digits");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [DIGIT:0]   w_dsum;
  logic             w_last;
  logic             w_c_msb;

  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  assign w_dsum  = digit_add(r_a_sh[DIGIT-1:0], r_b_sh[DIGIT-1:0], r_carry);
  assign w_last  = (r_cnt == CNT_W'(STEPS - 1));
  // Carry into the top bit of the digit, recovered from that bit's sum and operands.
  assign w_c_msb = w_dsum[DIGIT-1] ^ r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            // Subtract runs as A + ~B + ~cin, so the borrow-in is inverted into the carry.
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> DIGIT;
          r_b_sh   <= r_b_sh >> DIGIT;
          r_res_sh <= {w_dsum[DIGIT-1:0], r_res_sh[WIDTH-1:DIGIT]};
          r_carry  <= w_dsum[DIGIT];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            sum      <= {w_dsum[DIGIT-1:0], r_res_sh[WIDTH-1:DIGIT]};
            cout     <= w_dsum[DIGIT];
            overflow <= w_c_msb ^ w_dsum[DIGIT];
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: directed 8-bit/DIGIT=1 cases plus a randomised scoreboard
// over 16-bit instances with DIGIT = 1, 2, 4, 8 against a plain-arithmetic reference.
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub;
  logic        cin;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic [3:0]  st16;
  logic [15:0] a16, b16;
  logic [3:0]  busy16, done16, cout16, ovf16;
  logic [15:0] sum16 [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .cin(cin),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .overflow(ovf8)
  );

  for (genvar g = 0; g < 4; g++) begin : g_w16
    serial_digit_adder #(.WIDTH(16), .DIGIT(1 << g)) u_dut16 (
      .clk(clk), .rst(rst), .start(st16[g]), .sub(sub), .cin(cin),
      .a(a16), .b(b16), .busy(busy16[g]), .done(done16[g]), .sum(sum16[g]),
      .cout(cout16[g]), .overflow(ovf16[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned and signed results computed directly as integers.
  function automatic void ref_op(input int w, input longint ua, input longint ub,
                                 input bit s, input bit c, output longint rs,
                                 output bit rco, output bit rov);
    longint m, sa, sb, r, sr;
    m  = longint'(1) << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r   = ua + ub + longint'(c);
      rco = (r >= m);
      sr  = sa + sb + longint'(c);
    end else begin
      r   = ua - ub - longint'(c);
      rco = (r >= 0);
      sr  = sa - sb - longint'(c);
    end
    rs  = ((r % m) + m) % m;
    rov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
  endfunction

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                      input logic tc, input logic [7:0] es, input logic eco,
                      input logic eov, input string tag);
    int cyc;
    a8 = ta; b8 = tb_; sub = ts; cin = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check_eq({tag, "_busy_on"}, 32'(busy8), 32'd1);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'd8);
    check_eq({tag, "_sum"}, 32'(sum8), 32'(es));
    check_eq({tag, "_cout"}, 32'(cout8), 32'(eco));
    check_eq({tag, "_ovf"}, 32'(ovf8), 32'(eov));
    check_eq({tag, "_busy_off"}, 32'(busy8), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 32'(done8), 32'd0);
  endtask

  task automatic run16(input int k, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, input logic tc);
    int     cyc;
    longint es;
    bit     eco, eov;
    ref_op(16, longint'(ta), longint'(tb_), ts, tc, es, eco, eov);
    a16 = ta; b16 = tb_; sub = ts; cin = tc; st16[k] = 1'b1;
    @(posedge clk); #1;
    st16[k] = 1'b0;
    cyc = 0;
    while (!done16[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq($sformatf("d%0d_latency", 1 << k), 32'(cyc), 32'(16 >> k));
    check_eq($sformatf("d%0d_sum a=%h b=%h s=%0d c=%0d", 1 << k, ta, tb_, ts, tc),
             32'(sum16[k]), 32'(es));
    check_eq($sformatf("d%0d_cout", 1 << k), 32'(cout16[k]), 32'(eco));
    check_eq($sformatf("d%0d_ovf", 1 << k), 32'(ovf16[k]), 32'(eov));
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst = 1'b0; start8 = 1'b0; st16 = '0; sub = 1'b0; cin = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy8), 32'd0);
    check_eq("rst_done", 32'(done8), 32'd0);
    check_eq("rst_sum", 32'(sum8), 32'd0);
    check_eq("rst_cout", 32'(cout8), 32'd0);
    check_eq("rst_ovf", 32'(ovf8), 32'd0);
    check_eq("rst_busy16", 32'(busy16), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run8(8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run8(8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run8(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    run8(8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, "sub_05_02_b");
    run8(8'hC0, 8'h3F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "add_cin");

    // Start held high with operands churning; then back-to-back start in the done cycle.
    a8 = 8'h12; b8 = 8'h34; sub = 1'b0; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done8 && cyc < 20) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("hold_latency", 32'(cyc), 32'd8);
    check_eq("hold_sum", 32'(sum8), 32'h46);
    a8 = 8'h01; b8 = 8'h01; sub = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b2b_gap", 32'(cyc), 32'd9);
    check_eq("b2b_sum", 32'(sum8), 32'h02);

    // Reset landing on the fourth step aborts the operation silently.
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(busy8), 32'd0);
    check_eq("abort_done", 32'(done8), 32'd0);
    check_eq("abort_sum", 32'(sum8), 32'd0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen = 1'b1;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
    run8(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "after_abort");

    run16(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check_eq("d4_ffff_sum", 32'(sum16[2]), 32'h0000);
    check_eq("d4_ffff_cout", 32'(cout16[2]), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      run16(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
